// File: rtl/systolic_array_seq.sv
// ============================================================================
// Module  : systolic_array_seq
// Purpose : GEMM command sequencer for a systolic array. It streams weight and
//           input row beats into the array and collects output rows in a
//           credit-gated result FIFO. Optional SA_SEQ_PERF_EN adds performance
//           counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_array_seq #(
    parameter  int ARRAY_DIM = 4,
    parameter  int DATA_W    = 16,
    parameter  int RES_DEPTH = 8,
    localparam int RW        = $clog2(ARRAY_DIM),
    localparam int ROW_W     = DATA_W * ARRAY_DIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_reload_w,
    input  logic             cmd_psum,
    input  logic             beat_valid,
    output logic             beat_ready,
    input  logic [ROW_W-1:0] beat_data,
    input  logic [ROW_W-1:0] beat_psum,
    output logic             weight_en,
    output logic             input_en,
    output logic             partial_en,
    output logic [RW-1:0]    row_in_en,
    output logic [RW-1:0]    row_ps_en,
    output logic [ROW_W-1:0] array_in,
    output logic [ROW_W-1:0] array_in_partials,
    input  logic             drained,
    input  logic             fifo_has_space,
    input  logic             out_en,
    input  logic [RW-1:0]    row_out,
    input  logic [ROW_W-1:0] array_output,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RW-1:0]    res_row,
    output logic [ROW_W-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             overflow
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_gemms,
    output logic [31:0]      perf_stall
`endif
);

    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = RW + ROW_W;
    localparam logic [CW-1:0] C_DEPTH   = CW'(RES_DEPTH);
    localparam logic [CW-1:0] C_DIM     = CW'(ARRAY_DIM);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [RW-1:0] C_ROW_MAX = RW'(ARRAY_DIM - 1);
    localparam logic [RW:0]   C_ROWS    = (RW+1)'(ARRAY_DIM);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_W     = 3'd1,
        S_WAIT_SPACE = 3'd2,
        S_LOAD_IN    = 3'd3,
        S_DRAIN      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              psum_q;
    logic [RW-1:0]     row_q;
    logic [RW:0]       rows_seen_q;
    logic              weight_en_q, input_en_q, partial_en_q;
    logic [RW-1:0]     row_in_en_q, row_ps_en_q;
    logic [ROW_W-1:0]  array_in_q, array_in_partials_q;

    logic [EW-1:0]     mem_q [RES_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, reserved_q, reserved_d;
    logic              overflow_q;

    logic              w_cmd_fire, w_beat_fire, w_row_last;
    logic              w_reserve, w_stall, w_done;
    logic              w_empty, w_full, w_push, w_pop;
    logic [CW-1:0]     w_free;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == C_DEPTH);
    assign w_pop      = !w_empty && res_ready;
    assign w_push     = out_en && (!w_full || w_pop);
    // Free credits exclude both stored rows and rows promised to an in-flight GEMM.
    assign w_free     = C_DEPTH - count_q - reserved_q;
    assign w_row_last = (row_q == C_ROW_MAX);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_beat_fire = beat_valid && beat_ready;

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        beat_ready = 1'b0;
        w_reserve  = 1'b0;
        w_stall    = 1'b0;
        w_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst)
                    state_d = cmd_reload_w ? S_LOAD_W : S_WAIT_SPACE;
            end
            S_LOAD_W: begin
                beat_ready = !rst;
                if (beat_valid && w_row_last)
                    state_d = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                if (fifo_has_space && (w_free >= C_DIM)) begin
                    state_d   = S_LOAD_IN;
                    w_reserve = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_LOAD_IN: begin
                beat_ready = !rst;
                if (beat_valid && w_row_last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((rows_seen_q == C_ROWS) && drained) begin
                    w_done  = !rst;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            psum_q      <= 1'b0;
            row_q       <= '0;
            rows_seen_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_cmd_fire) begin
                psum_q      <= cmd_psum;
                row_q       <= '0;
                rows_seen_q <= '0;
            end else begin
                if (w_beat_fire)
                    row_q <= w_row_last ? '0 : row_q + RW'(1);
                if (out_en && (state_q != S_IDLE) && (rows_seen_q != C_ROWS))
                    rows_seen_q <= rows_seen_q + (RW+1)'(1);
            end
        end
    end

    // Array strobes are single-cycle; row indices and data hold between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_en_q         <= 1'b0;
            input_en_q          <= 1'b0;
            partial_en_q        <= 1'b0;
            row_in_en_q         <= '0;
            row_ps_en_q         <= '0;
            array_in_q          <= '0;
            array_in_partials_q <= '0;
        end else begin
            weight_en_q  <= 1'b0;
            input_en_q   <= 1'b0;
            partial_en_q <= 1'b0;
            if (w_beat_fire) begin
                row_in_en_q <= row_q;
                array_in_q  <= beat_data;
                if (state_q == S_LOAD_W) begin
                    weight_en_q <= 1'b1;
                end else begin
                    input_en_q <= 1'b1;
                    if (psum_q) begin
                        partial_en_q        <= 1'b1;
                        row_ps_en_q         <= row_q;
                        array_in_partials_q <= beat_psum;
                    end else begin
                        row_ps_en_q         <= '0;
                        array_in_partials_q <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        reserved_d = reserved_q;
        if (w_push && (reserved_q != '0))
            reserved_d = reserved_d - C_ONE;
        if (w_reserve)
            reserved_d = reserved_d + C_DIM;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            mem_q[wr_ptr_q] <= {row_out, array_output};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            if (w_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_push && !w_pop)
                count_q <= count_q + C_ONE;
            else if (w_pop && !w_push)
                count_q <= count_q - C_ONE;
            if (out_en && w_full && !w_pop)
                overflow_q <= 1'b1;
        end
    end

`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_gemms_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_gemms_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (w_done)
                perf_gemms_q <= perf_gemms_q + 32'd1;
            if (w_stall)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_gemms = perf_gemms_q;
    assign perf_stall = perf_stall_q;
`endif

    assign weight_en         = weight_en_q;
    assign input_en          = input_en_q;
    assign partial_en        = partial_en_q;
    assign row_in_en         = row_in_en_q;
    assign row_ps_en         = row_ps_en_q;
    assign array_in          = array_in_q;
    assign array_in_partials = array_in_partials_q;
    assign res_valid         = !w_empty;
    assign res_row           = w_empty ? '0 : mem_q[rd_ptr_q][EW-1:ROW_W];
    assign res_data          = w_empty ? '0 : mem_q[rd_ptr_q][ROW_W-1:0];
    assign busy              = (state_q != S_IDLE);
    assign done              = w_done;
    assign overflow          = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_seq.sv
// ============================================================================
// Module  : tb_systolic_array_seq
// Purpose : Directed self-checking bench for systolic_array_seq (4x4, 16-bit,
//           8-entry result FIFO).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_systolic_array_seq;

    localparam int AD = 4;
    localparam int DW = 16;
    localparam int RD = 8;
    localparam int RW = 2;
    localparam int ROW_W = DW * AD;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_reload_w, cmd_psum;
    logic             beat_valid, beat_ready;
    logic [ROW_W-1:0] beat_data, beat_psum;
    logic             weight_en, input_en, partial_en;
    logic [RW-1:0]    row_in_en, row_ps_en;
    logic [ROW_W-1:0] array_in, array_in_partials;
    logic             drained, fifo_has_space, out_en;
    logic [RW-1:0]    row_out;
    logic [ROW_W-1:0] array_output;
    logic             res_valid, res_ready;
    logic [RW-1:0]    res_row;
    logic [ROW_W-1:0] res_data;
    logic             busy, done, overflow;
`ifdef SA_SEQ_PERF_EN
    logic [31:0]      perf_gemms, perf_stall;
`endif

    always #5 clk = ~clk;

    systolic_array_seq #(.ARRAY_DIM(AD), .DATA_W(DW), .RES_DEPTH(RD)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reload_w(cmd_reload_w), .cmd_psum(cmd_psum),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_data(beat_data), .beat_psum(beat_psum),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .drained(drained), .fifo_has_space(fifo_has_space), .out_en(out_en),
        .row_out(row_out), .array_output(array_output),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_data(res_data),
        .busy(busy), .done(done), .overflow(overflow)
`ifdef SA_SEQ_PERF_EN
        , .perf_gemms(perf_gemms), .perf_stall(perf_stall)
`endif
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int wen_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (weight_en === 1'b1) wen_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] mkrow(input logic [15:0] t);
        return {t, t, t, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic rw, input logic ps);
        cmd_valid = 1'b1; cmd_reload_w = rw; cmd_psum = ps;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("busy_after_cmd", busy, 1'b1);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic send_beat(input logic is_w, input logic [63:0] d, input logic [63:0] p,
                             input int r, input logic ps);
        beat_valid = 1'b1; beat_data = d; beat_psum = p;
        #1;
        for (int n = 0; n < 40 && !beat_ready; n++) tick();
        chk("beat_ready_wait", beat_ready, 1'b1);
        tick();
        chk("weight_en", weight_en, is_w);
        chk("input_en", input_en, !is_w);
        chk("row_in_en", row_in_en, r[RW-1:0]);
        chk("array_in", array_in, d);
        if (!is_w) begin
            chk("partial_en", partial_en, ps);
            chk("row_ps_en", row_ps_en, ps ? r[RW-1:0] : 2'd0);
            chk("array_in_partials", array_in_partials, ps ? p : 64'd0);
        end
    endtask

    task automatic push_row(input logic [15:0] tag);
        out_en = 1'b1; row_out = tag[RW-1:0]; array_output = mkrow(tag);
        tick();
        out_en = 1'b0;
    endtask

    task automatic pop_chk(input logic [15:0] tag);
        res_ready = 1'b1;
        #1;
        chk("res_valid_pop", res_valid, 1'b1);
        chk("res_row", res_row, tag[RW-1:0]);
        chk("res_data", res_data, mkrow(tag));
        tick();
        res_ready = 1'b0;
    endtask

    task automatic finish_gemm();
        drained = 1'b1;
        #1;
        chk("done_pulse", done, 1'b1);
        tick();
        drained = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("done_low", done, 1'b0);
    endtask

    task automatic input_phase(input logic [15:0] base, input logic ps);
        for (int r = 0; r < AD; r++)
            send_beat(1'b0, mkrow(base + 16'(r)), mkrow(16'h00AA), r, ps);
        beat_valid = 1'b0;
        #1;
        chk("beat_ready_drain", beat_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] tags [8];
        rst = 1'b1; cmd_valid = 1'b0; cmd_reload_w = 1'b0; cmd_psum = 1'b0;
        beat_valid = 1'b0; beat_data = '0; beat_psum = '0;
        drained = 1'b0; fifo_has_space = 1'b1; out_en = 1'b0;
        row_out = '0; array_output = '0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_beat_ready", beat_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_array_in", array_in, 64'd0);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // GEMM 1: weight reload, no psum, space withheld for 10 cycles.
        fifo_has_space = 1'b0;
        start_cmd(1'b1, 1'b0);
        chk("load_w_ready_t1", beat_ready, 1'b1);
        for (int r = 0; r < AD; r++)
            send_beat(1'b1, mkrow(16'(16'h1111 * (r + 1))), 64'd0, r, 1'b0);
        beat_valid = 1'b0;
        repeat (10) begin
            #1;
            chk("stall_beat_ready", beat_ready, 1'b0);
            tick();
        end
        fifo_has_space = 1'b1;
        #1;
        chk("space_rise_ready", beat_ready, 1'b0);
        tick();
        chk("load_in_entered", beat_ready, 1'b1);
        input_phase(16'hA000, 1'b0);
        chk("res_empty_before", res_valid, 1'b0);
        for (int r = 0; r < AD; r++) begin
            push_row(16'h0100 + 16'(r));
            if (r == 0) chk("res_valid_t1", res_valid, 1'b1);
        end
        finish_gemm();
        chk("done_cnt_g1", done_cnt, 1);
        chk("wen_cnt_g1", wen_cnt, 4);
        for (int r = 0; r < AD; r++) pop_chk(16'h0100 + 16'(r));
        chk("res_empty_g1", res_valid, 1'b0);

        // GEMM 2: no reload, psum rows.
        start_cmd(1'b0, 1'b1);
        chk("wait_ready_t1", beat_ready, 1'b0);
        tick();
        chk("load_in_ready_t2", beat_ready, 1'b1);
        input_phase(16'hB000, 1'b1);
        for (int r = 0; r < AD; r++) push_row(16'h0200 + 16'(r));
        finish_gemm();
        chk("done_cnt_g2", done_cnt, 2);
        chk("wen_cnt_g2", wen_cnt, 4);

        // GEMM 3 fills the FIFO; GEMM 4 must wait for credits.
        start_cmd(1'b0, 1'b0);
        input_phase(16'hC000, 1'b0);
        for (int r = 0; r < AD; r++) push_row(16'h0300 + 16'(r));
        finish_gemm();
        start_cmd(1'b0, 1'b0);
        repeat (5) begin
            #1;
            chk("credit_stall", beat_ready, 1'b0);
            tick();
        end
        for (int r = 0; r < AD; r++) begin
            chk("credit_stall_pop", beat_ready, 1'b0);
            pop_chk(16'h0200 + 16'(r));
        end
        input_phase(16'hD000, 1'b0);
        for (int r = 0; r < AD; r++) push_row(16'h0400 + 16'(r));
        finish_gemm();
        chk("done_cnt_g4", done_cnt, 4);
        chk("overflow_after_g4", overflow, 1'b0);

        // Full FIFO: push with pop both occur; push alone is dropped.
        res_ready = 1'b1;
        push_row(16'h0501);
        res_ready = 1'b0;
        chk("full_pushpop_ovf", overflow, 1'b0);
        push_row(16'h0602);
        chk("full_push_ovf", overflow, 1'b1);
        tags = '{16'h0301, 16'h0302, 16'h0303, 16'h0400, 16'h0401, 16'h0402, 16'h0403, 16'h0501};
        for (int i = 0; i < 8; i++) pop_chk(tags[i]);
        #1;
        chk("res_empty_final", res_valid, 1'b0);

        // Reset in the middle of the input phase.
        push_row(16'h0700);
        start_cmd(1'b0, 1'b1);
        send_beat(1'b0, mkrow(16'hE000), mkrow(16'h00AA), 0, 1'b1);
        send_beat(1'b0, mkrow(16'hE001), mkrow(16'h00AA), 1, 1'b1);
        beat_data = mkrow(16'hE002);
        rst = 1'b1;
        tick();
        chk("mid_rst_input_en", input_en, 1'b0);
        chk("mid_rst_partial_en", partial_en, 1'b0);
        chk("mid_rst_row_in", row_in_en, 2'd0);
        chk("mid_rst_row_ps", row_ps_en, 2'd0);
        chk("mid_rst_array_in", array_in, 64'd0);
        chk("mid_rst_partials", array_in_partials, 64'd0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        beat_valid = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        tick();
        chk("post_rst_done_cnt", done_cnt, 4);
        chk("post_rst_res_valid", res_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
